tof_ctrl_regbank: RTL and testbench



---
 rtl/tof_ctrl_regbank.sv | 196 +++++++++++++++++++
 tb/tb_tof_ctrl_regbank.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tof_ctrl_regbank.sv
// TOF controller register bank: config words, monitoring words, host register bus, update handshake.
// Define TOF_REGBANK_MON_SNAPSHOT_EN to double-buffer the monitoring words behind a coherent copier.
module tof_ctrl_regbank #(
  parameter int unsigned NUM_CFG          = 66,
  parameter int unsigned NUM_MON          = 77,
  parameter logic [31:0] TIMEOUT          = 32'd200000000,
  parameter logic [15:0] MON_RATE_DEFAULT = 16'd1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  host_addr_i,
  input  logic [15:0] host_dat_i,
  input  logic        host_wr_i,
  input  logic        host_rd_i,
  output logic [15:0] host_dat_o,
  output logic        host_ack_o,
  input  logic [6:0]  cfg_addr_i,
  output logic [15:0] cfg_dat_o,
  input  logic [6:0]  mon_addr_i,
  input  logic [15:0] mon_dat_i,
  input  logic        mon_wr_i,
  output logic [15:0] mon_rate_o,
  input  logic        ready_i,
  output logic        update_o,
  input  logic        updating_i,
  input  logic        update_complete_i
);

  localparam logic [6:0] NumCfgW = 7'(NUM_CFG);
  localparam logic [6:0] NumMonW = 7'(NUM_MON);

  typedef enum logic [1:0] {StIdle, StPulse, StWait} state_e;

  state_e      state_q;
  logic [31:0] timer_q;
  logic        done_q;
  logic        error_q;
  logic        cmp_s_q;
  logic        cmp_d_q;
  logic        cmp_rise;
  logic        busy;
  logic        snap_busy;

  logic [15:0] cfg_q [NUM_CFG];
  logic [15:0] mon_q [NUM_MON];
  logic [15:0] rd_data;
  logic [15:0] mon_rd;

  logic cfg_wr;
  logic ctrl_wr;
  logic rate_wr;
  logic upd_req;
  logic sticky_clr;
  logic unused_updating;

  // The controller's in-progress flag carries no information the handshake needs.
  assign unused_updating = updating_i;

  assign cfg_wr     = host_wr_i && !host_addr_i[7] && (host_addr_i[6:0] < NumCfgW);
  assign ctrl_wr    = host_wr_i && (host_addr_i == 8'hF0);
  assign rate_wr    = host_wr_i && (host_addr_i == 8'hF1);
  assign upd_req    = ctrl_wr && host_dat_i[0];
  assign sticky_clr = ctrl_wr && host_dat_i[8];
  assign cmp_rise   = cmp_s_q && !cmp_d_q;
  assign busy       = (state_q != StIdle);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NUM_CFG); i++) cfg_q[i] <= 16'h0000;
      cfg_dat_o  <= 16'h0000;
      mon_rate_o <= MON_RATE_DEFAULT;
    end else begin
      if (cfg_wr) cfg_q[host_addr_i[6:0]] <= host_dat_i;
      if (rate_wr) mon_rate_o <= host_dat_i;
      cfg_dat_o <= (cfg_addr_i < NumCfgW) ? cfg_q[cfg_addr_i] : 16'h0000;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NUM_MON); i++) mon_q[i] <= 16'h0000;
    end else if (mon_wr_i && (mon_addr_i < NumMonW)) begin
      mon_q[mon_addr_i] <= mon_dat_i;
    end
  end

`ifdef TOF_REGBANK_MON_SNAPSHOT_EN
  localparam logic [6:0] LastMon = 7'(NUM_MON - 1);

  logic [15:0] mon_host_q [NUM_MON];
  logic [6:0]  copy_idx_q;
  logic        snap_busy_q;
  logic        done_set;

  assign done_set  = (state_q == StWait) && cmp_rise;
  assign snap_busy = snap_busy_q;
  assign mon_rd    = mon_host_q[host_addr_i[6:0]];

  // A fresh done restarts the copy so the host bank always reflects one complete cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NUM_MON); i++) mon_host_q[i] <= 16'h0000;
      copy_idx_q  <= 7'd0;
      snap_busy_q <= 1'b0;
    end else if (done_set) begin
      copy_idx_q  <= 7'd0;
      snap_busy_q <= 1'b1;
    end else if (snap_busy_q) begin
      mon_host_q[copy_idx_q] <= mon_q[copy_idx_q];
      if (copy_idx_q == LastMon) begin
        snap_busy_q <= 1'b0;
      end else begin
        copy_idx_q <= copy_idx_q + 7'd1;
      end
    end
  end
`else
  assign snap_busy = 1'b0;
  assign mon_rd    = mon_q[host_addr_i[6:0]];
`endif

  always_comb begin
    rd_data = 16'h0000;
    if (!host_addr_i[7]) begin
      if (host_addr_i[6:0] < NumCfgW) rd_data = cfg_q[host_addr_i[6:0]];
    end else if (host_addr_i[6:0] < NumMonW) begin
      rd_data = mon_rd;
    end else if (host_addr_i == 8'hF0) begin
      rd_data = {8'h00, snap_busy, 3'b000, error_q, done_q, busy, ready_i};
    end else if (host_addr_i == 8'hF1) begin
      rd_data = mon_rate_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      host_ack_o <= 1'b0;
      host_dat_o <= 16'h0000;
    end else begin
      host_ack_o <= host_wr_i || host_rd_i;
      host_dat_o <= host_rd_i ? rd_data : 16'h0000;
    end
  end

  // Input stage plus delay stage; the rise is seen one cycle after update_complete_i goes high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmp_s_q <= 1'b0;
      cmp_d_q <= 1'b0;
    end else begin
      cmp_s_q <= update_complete_i;
      cmp_d_q <= cmp_s_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      timer_q  <= 32'd0;
      update_o <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      update_o <= 1'b0;
      if (sticky_clr) begin
        done_q  <= 1'b0;
        error_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (upd_req && ready_i) begin
            state_q  <= StPulse;
            update_o <= 1'b1;
          end
        end
        StPulse: begin
          timer_q <= 32'd0;
          state_q <= StWait;
        end
        StWait: begin
          if (cmp_rise) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else if (timer_q == TIMEOUT - 32'd1) begin
            error_q <= 1'b1;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tof_ctrl_regbank.sv
// Self-checking bench for tof_ctrl_regbank against a behavioural register-map model.
module tb_tof_ctrl_regbank;

  localparam int NCFG = 66;
  localparam int NMON = 77;
  localparam logic [31:0] TMO = 32'd100;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  host_addr_i = 8'h00;
  logic [15:0] host_dat_i = 16'h0000;
  logic        host_wr_i = 1'b0;
  logic        host_rd_i = 1'b0;
  logic [15:0] host_dat_o;
  logic        host_ack_o;
  logic [6:0]  cfg_addr_i = 7'h00;
  logic [15:0] cfg_dat_o;
  logic [6:0]  mon_addr_i = 7'h00;
  logic [15:0] mon_dat_i = 16'h0000;
  logic        mon_wr_i = 1'b0;
  logic [15:0] mon_rate_o;
  logic        ready_i = 1'b0;
  logic        update_o;
  logic        updating_i = 1'b0;
  logic        update_complete_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int pulse_cnt = 0;
  int lat;
  logic found;

  logic [15:0] cfg_m [NCFG];
  logic [15:0] mon_m [NMON];
  logic [15:0] mon_h [NMON];
  logic [15:0] rate_m;
  logic [7:0]  ra;
  logic [15:0] rd;
  logic [15:0] md;
  logic [6:0]  rca;
  logic [6:0]  rma;
  logic        rwr;
  logic        rmw;
  logic [15:0] exp_h;
  logic [15:0] exp_c;

  tof_ctrl_regbank #(
    .NUM_CFG          (NCFG),
    .NUM_MON          (NMON),
    .TIMEOUT          (TMO),
    .MON_RATE_DEFAULT (16'd1000)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .host_addr_i       (host_addr_i),
    .host_dat_i        (host_dat_i),
    .host_wr_i         (host_wr_i),
    .host_rd_i         (host_rd_i),
    .host_dat_o        (host_dat_o),
    .host_ack_o        (host_ack_o),
    .cfg_addr_i        (cfg_addr_i),
    .cfg_dat_o         (cfg_dat_o),
    .mon_addr_i        (mon_addr_i),
    .mon_dat_i         (mon_dat_i),
    .mon_wr_i          (mon_wr_i),
    .mon_rate_o        (mon_rate_o),
    .ready_i           (ready_i),
    .update_o          (update_o),
    .updating_i        (updating_i),
    .update_complete_i (update_complete_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (update_o) pulse_cnt++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCFG; i++) cfg_m[i] = 16'h0000;
    for (int i = 0; i < NMON; i++) begin
      mon_m[i] = 16'h0000;
      mon_h[i] = 16'h0000;
    end
    rate_m = 16'd1000;
  endtask

  // Expected host read value with idle update logic and clear sticky flags.
  function automatic logic [15:0] ref_read(input logic [7:0] a);
    int ai;
    ai = int'(a);
    if (ai < NCFG) return cfg_m[ai];
    if (ai >= 128 && ai < 128 + NMON) begin
`ifdef TOF_REGBANK_MON_SNAPSHOT_EN
      return mon_h[ai - 128];
`else
      return mon_m[ai - 128];
`endif
    end
    if (a == 8'hF0) return {15'd0, ready_i};
    if (a == 8'hF1) return rate_m;
    return 16'h0000;
  endfunction

  // Drive one host strobe at a falling edge; returns one cycle later with the response visible.
  task automatic host_op(input logic [7:0] a, input logic [15:0] d, input logic wr, input logic rdn);
    host_addr_i = a;
    host_dat_i  = d;
    host_wr_i   = wr;
    host_rd_i   = rdn;
    @(negedge clk);
    host_wr_i = 1'b0;
    host_rd_i = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_update", {15'd0, update_o}, 16'h0000);
    check("rst_ack", {15'd0, host_ack_o}, 16'h0000);
    check("rst_hdat", host_dat_o, 16'h0000);
    check("rst_cfgdat", cfg_dat_o, 16'h0000);
    check("rst_rate", mon_rate_o, 16'h03E8);
    rst_i = 1'b0;
    @(negedge clk);

    host_op(8'hF1, 16'h0000, 1'b0, 1'b1);
    check("rd_f1_ack", {15'd0, host_ack_o}, 16'h0001);
    check("rd_f1", host_dat_o, 16'h03E8);
    host_op(8'h05, 16'h0000, 1'b0, 1'b1);
    check("rd_05", host_dat_o, 16'h0000);

    host_op(8'h12, 16'hBEEF, 1'b1, 1'b0);
    cfg_m[18] = 16'hBEEF;
    check("wr_ack", {15'd0, host_ack_o}, 16'h0001);
    cfg_addr_i = 7'h12;
    @(negedge clk);
    check("cfg_12", cfg_dat_o, 16'hBEEF);
    cfg_addr_i = 7'h50;
    @(negedge clk);
    check("cfg_50", cfg_dat_o, 16'h0000);
    host_op(8'h41, 16'h5A5A, 1'b1, 1'b0);
    cfg_m[65] = 16'h5A5A;
    host_op(8'h42, 16'h1111, 1'b1, 1'b0);
    cfg_addr_i = 7'h41;
    @(negedge clk);
    check("cfg_41", cfg_dat_o, 16'h5A5A);
    cfg_addr_i = 7'h42;
    @(negedge clk);
    check("cfg_42", cfg_dat_o, 16'h0000);
    host_op(8'h42, 16'h0000, 1'b0, 1'b1);
    check("rd_42", host_dat_o, 16'h0000);

`ifndef TOF_REGBANK_MON_SNAPSHOT_EN
    mon_addr_i = 7'h4C; mon_dat_i = 16'h1234; mon_wr_i = 1'b1;
    @(negedge clk);
    mon_addr_i = 7'h4D; mon_dat_i = 16'hFFFF;
    @(negedge clk);
    mon_wr_i = 1'b0;
    mon_m[76] = 16'h1234;
    host_op(8'hCC, 16'h0000, 1'b0, 1'b1);
    check("rd_cc", host_dat_o, 16'h1234);
    host_op(8'hCD, 16'h0000, 1'b0, 1'b1);
    check("rd_cd", host_dat_o, 16'h0000);
    // Controller write and host read of one word in the same cycle: host sees the old value.
    mon_addr_i = 7'h4C; mon_dat_i = 16'h5555; mon_wr_i = 1'b1;
    host_op(8'hCC, 16'h0000, 1'b0, 1'b1);
    mon_wr_i = 1'b0;
    mon_m[76] = 16'h5555;
    check("rd_cc_old", host_dat_o, 16'h1234);
    host_op(8'hCC, 16'h0000, 1'b0, 1'b1);
    check("rd_cc_new", host_dat_o, 16'h5555);
`endif

    // Random back-to-back traffic on all three ports, expectations taken before this cycle's writes.
    for (int i = 0; i < 300; i++) begin
      rwr = ($urandom_range(0, 2) == 0);
      ra  = 8'($urandom_range(0, 255));
      if (rwr && ra == 8'hF0) ra = 8'hF1;
      rd  = 16'($urandom);
      rca = 7'($urandom_range(0, 127));
      rma = 7'($urandom_range(0, 127));
      rmw = 1'($urandom_range(0, 1));
      md  = 16'($urandom);
      exp_h = ref_read(ra);
      exp_c = (int'(rca) < NCFG) ? cfg_m[rca] : 16'h0000;
      host_addr_i = ra; host_dat_i = rd; host_wr_i = rwr; host_rd_i = !rwr;
      cfg_addr_i = rca; mon_addr_i = rma; mon_dat_i = md; mon_wr_i = rmw;
      if (rwr) begin
        if (int'(ra) < NCFG) cfg_m[ra] = rd;
        else if (ra == 8'hF1) rate_m = rd;
      end
      if (rmw && int'(rma) < NMON) mon_m[rma] = md;
      @(negedge clk);
      check("rnd_ack", {15'd0, host_ack_o}, 16'h0001);
      if (!rwr) check("rnd_hdat", host_dat_o, exp_h);
      check("rnd_cfgdat", cfg_dat_o, exp_c);
    end
    host_wr_i = 1'b0; host_rd_i = 1'b0; mon_wr_i = 1'b0;
    check("rnd_rate", mon_rate_o, rate_m);

    // Completed update.
    ready_i = 1'b1;
    host_op(8'hF0, 16'h0001, 1'b1, 1'b0);
    check("upd_pulse", {15'd0, update_o}, 16'h0001);
    host_op(8'hF0, 16'h0000, 1'b0, 1'b1);
    check("upd_busy", host_dat_o, 16'h0003);
    check("upd_one", {15'd0, update_o}, 16'h0000);
    repeat (8) @(negedge clk);
    update_complete_i = 1'b1;
    host_addr_i = 8'hF0; host_rd_i = 1'b1;
    found = 1'b0; lat = -1;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (host_dat_o[2]) begin found = 1'b1; lat = k; end
    end
    host_rd_i = 1'b0;
    check("done_lat", 16'(lat), 16'd2);
    host_op(8'hF0, 16'h0000, 1'b0, 1'b1);
    check("done_stat", host_dat_o, 16'h0005);
    check("pulse_cnt1", 16'(pulse_cnt), 16'd1);
    host_op(8'hF0, 16'h0100, 1'b1, 1'b0);
    host_op(8'hF0, 16'h0000, 1'b0, 1'b1);
    check("done_clr", host_dat_o, 16'h0001);

    // Timed-out update with a second request issued while busy.
    update_complete_i = 1'b0;
    host_op(8'hF0, 16'h0001, 1'b1, 1'b0);
    check("tmo_pulse", {15'd0, update_o}, 16'h0001);
    host_addr_i = 8'hF0; host_dat_i = 16'h0001; host_wr_i = 1'b1;
    @(negedge clk);
    host_wr_i = 1'b0; host_rd_i = 1'b1;
    found = 1'b0; lat = -1;
    for (int k = 2; k < 300 && !found; k++) begin
      @(negedge clk);
      if (host_dat_o[3]) begin found = 1'b1; lat = k; end
    end
    host_rd_i = 1'b0;
    check("tmo_lat", 16'(lat), 16'(TMO + 32'd2));
    check("tmo_stat", host_dat_o, 16'h0009);
    repeat (3) @(negedge clk);
    check("pulse_cnt2", 16'(pulse_cnt), 16'd2);

    // Request while not ready is ignored; clear bit drops the error.
    ready_i = 1'b0;
    host_op(8'hF0, 16'h0101, 1'b1, 1'b0);
    check("nrdy_pulse", {15'd0, update_o}, 16'h0000);
    host_op(8'hF0, 16'h0000, 1'b0, 1'b1);
    check("err_clr", host_dat_o, 16'h0000);
    repeat (3) @(negedge clk);
    check("pulse_cnt3", 16'(pulse_cnt), 16'd2);

    // Reset with an update pulse in flight.
    cfg_addr_i = 7'h12;
    host_op(8'h12, 16'hBEEF, 1'b1, 1'b0);
    host_op(8'hF1, 16'h4321, 1'b1, 1'b0);
    ready_i = 1'b1;
    host_op(8'hF0, 16'h0001, 1'b1, 1'b0);
    check("mid_pulse", {15'd0, update_o}, 16'h0001);
    check("mid_cfg", cfg_dat_o, 16'hBEEF);
    rst_i = 1'b1;
    #1;
    check("mid_upd_drop", {15'd0, update_o}, 16'h0000);
    check("mid_rate", mon_rate_o, 16'h03E8);
    check("mid_cfgdat", cfg_dat_o, 16'h0000);
    @(negedge clk);
    rst_i = 1'b0;
    model_reset();
    host_op(8'h12, 16'h0000, 1'b0, 1'b1);
    check("mid_rd12", host_dat_o, 16'h0000);
    check("pulse_cnt4", 16'(pulse_cnt), 16'd2);

`ifdef TOF_REGBANK_MON_SNAPSHOT_EN
    mon_addr_i = 7'h00; mon_dat_i = 16'h00AA; mon_wr_i = 1'b1;
    @(negedge clk);
    mon_wr_i = 1'b0;
    mon_m[0] = 16'h00AA;
    host_op(8'h80, 16'h0000, 1'b0, 1'b1);
    check("snap_pre", host_dat_o, 16'h0000);
    host_op(8'hF0, 16'h0001, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    update_complete_i = 1'b1;
    repeat (10) @(negedge clk);
    host_op(8'hF0, 16'h0000, 1'b0, 1'b1);
    check("snap_busy", host_dat_o, 16'h0085);
    repeat (NMON + 2) @(negedge clk);
    for (int i = 0; i < NMON; i++) mon_h[i] = mon_m[i];
    host_op(8'h80, 16'h0000, 1'b0, 1'b1);
    check("snap_post", host_dat_o, 16'h00AA);
    host_op(8'hF0, 16'h0000, 1'b0, 1'b1);
    check("snap_done", host_dat_o, 16'h0005);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
